// File: rtl/butterfly_pipe.sv
// butterfly_pipe: two-stage radix-2 butterfly with twiddle select, valid/ready handshake and sticky overflow
module butterfly_pipe #(
    parameter int N = 4,
    parameter int SCALE = 0,
    parameter int SAT = 0,
    localparam int W = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [W-1:0] in_1_r,
    input  logic [W-1:0] in_1_i,
    input  logic [W-1:0] in_2_r,
    input  logic [W-1:0] in_2_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_1_r,
    output logic [W-1:0] out_1_i,
    output logic [W-1:0] out_2_r,
    output logic [W-1:0] out_2_i,
    output logic         ovf,
    input  logic         ovf_clr
);
    localparam int P = 2 * W + 3;

    function automatic longint unsigned isqrt_round(input longint unsigned x);
        longint unsigned s, t;
        s = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            t = s | (64'd1 << b);
            if (t * t <= x) s = t;
        end
        return (64'd4 * x >= (64'd2 * s + 64'd1) * (64'd2 * s + 64'd1)) ? s + 64'd1 : s;
    endfunction

    // 1/sqrt2 in Q1.(W-1): sqrt(2**(2W-3)) rounded to nearest
    localparam logic [W-1:0] C = W'(isqrt_round(64'd1 << (2 * W - 3)));
    localparam logic signed [P-1:0] HALF = P'(64'd1 << (W - 2));

    // scale by C with round-half-up, then saturate to W+1 bits
    function automatic logic signed [W:0] rot(input logic signed [W+1:0] a);
        logic signed [P-1:0] q;
        q = (P'(a) * $signed(P'({1'b0, C})) + HALF) >>> (W - 1);
        return (&q[P-1:W] || ~|q[P-1:W]) ? q[W:0] : {q[P-1], {W{~q[P-1]}}};
    endfunction

    // optional halving, then wrap or saturate to W bits; top bit flags a changed value
    function automatic logic [W:0] fin(input logic signed [W+1:0] x);
        logic signed [W+1:0] y;
        logic ok;
        y = (SCALE != 0) ? x >>> 1 : x;
        ok = &y[W+1:W-1] || ~|y[W+1:W-1];
        return {!ok, (ok || SAT == 0) ? y[W-1:0] : {y[W+1], {(W-1){~y[W+1]}}}};
    endfunction

    logic en1, en2, s1_valid, ovf_now;
    logic signed [W:0] b_r, b_i, t_r, t_i, t1_r, t1_i;
    logic signed [W+1:0] sum, dif;
    logic signed [W-1:0] a1_r, a1_i;
    logic [W:0] f1_r, f1_i, f2_r, f2_i;

    assign en2 = !out_valid || out_ready;
    assign en1 = !s1_valid || en2;
    assign in_ready = en1;

    // twiddle product; sums kept at W+2 bits so -r-i cannot wrap at the negative corner
    always_comb begin
        b_r = (W+1)'($signed(in_2_r));
        b_i = (W+1)'($signed(in_2_i));
        sum = (W+2)'(b_r) + (W+2)'(b_i);
        dif = (W+2)'(b_i) - (W+2)'(b_r);
        t_r = mode == 2'd0 ? b_r : mode == 2'd1 ? b_i : mode == 2'd2 ? rot(sum) : rot(dif);
        t_i = mode == 2'd0 ? b_i : mode == 2'd1 ? -b_r : mode == 2'd2 ? rot(dif) : rot(-sum);
    end

    // butterfly add/subtract at W+2 bits and final narrowing
    always_comb begin
        f1_r = fin((W+2)'(a1_r) + (W+2)'(t1_r));
        f1_i = fin((W+2)'(a1_i) + (W+2)'(t1_i));
        f2_r = fin((W+2)'(a1_r) - (W+2)'(t1_r));
        f2_i = fin((W+2)'(a1_i) - (W+2)'(t1_i));
        ovf_now = f1_r[W] | f1_i[W] | f2_r[W] | f2_i[W];
    end

    // stage 1: capture operand 1 and twiddle product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            a1_r <= '0;
            a1_i <= '0;
            t1_r <= '0;
            t1_i <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            a1_r <= $signed(in_1_r);
            a1_i <= $signed(in_1_i);
            t1_r <= t_r;
            t1_i <= t_i;
        end
    end

    // stage 2: register butterfly results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_1_r <= '0;
            out_1_i <= '0;
            out_2_r <= '0;
            out_2_i <= '0;
        end else if (en2) begin
            out_valid <= s1_valid;
            out_1_r <= f1_r[W-1:0];
            out_1_i <= f1_i[W-1:0];
            out_2_r <= f2_r[W-1:0];
            out_2_i <= f2_i[W-1:0];
        end
    end

    // sticky overflow; a new overflow beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else ovf <= (s1_valid && en2 && ovf_now) || (ovf && !ovf_clr);
    end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed vectors for three butterfly_pipe configurations against an arithmetic model
module tb_butterfly_pipe;
    localparam int N = 4;
    localparam int W = 16;
    localparam longint M = 64'sd1 << W;

    typedef struct {
        int m;
        longint ar, ai, br, bi;
    } smp_t;

    logic clk = 0, rst = 0, in_valid = 0, out_ready = 1, ovf_clr = 0;
    logic [1:0] mode = 0;
    logic [W-1:0] i1r = 0, i1i = 0, i2r = 0, i2i = 0;
    logic ir[3], vo[3], ov[3];
    logic [W-1:0] o1r[3], o1i[3], o2r[3], o2i[3];

    // instance 0: wrap, 1: saturate, 2: scale with wrap
    for (genvar k = 0; k < 3; k++) begin : g
        butterfly_pipe #(.N(N), .SCALE(k == 2 ? 1 : 0), .SAT(k == 1 ? 1 : 0)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[k]), .mode(mode),
            .in_1_r(i1r), .in_1_i(i1i), .in_2_r(i2r), .in_2_i(i2i),
            .out_valid(vo[k]), .out_ready(out_ready),
            .out_1_r(o1r[k]), .out_1_i(o1i[k]), .out_2_r(o2r[k]), .out_2_i(o2i[k]),
            .ovf(ov[k]), .ovf_clr(ovf_clr)
        );
    end

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, delivered = 0;
    smp_t q[$];

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint rnd(input longint x);
        longint cc;
        cc = longint'($floor((2.0 ** (W - 1)) / $sqrt(2.0) + 0.5));
        return longint'($floor(real'(x) * real'(cc) / (2.0 ** (W - 1)) + 0.5));
    endfunction

    function automatic longint narrow(input longint x, input bit scale, input bit sat, inout bit ovr);
        longint y, w;
        y = scale ? longint'($floor(real'(x) / 2.0)) : x;
        if (y > M / 2 - 1 || y < -M / 2) ovr = 1;
        w = ((y % M) + M) % M;
        if (w >= M / 2) w -= M;
        return !sat ? w : (y > M / 2 - 1) ? M / 2 - 1 : (y < -M / 2) ? -M / 2 : y;
    endfunction

    // complex arithmetic straight from the twiddle table
    function automatic void model(input smp_t s, input bit scale, input bit sat,
                                  output longint e1r, output longint e1i,
                                  output longint e2r, output longint e2i, output bit ovr);
        longint tr, ti;
        case (s.m)
            0: begin tr = s.br; ti = s.bi; end
            1: begin tr = s.bi; ti = -s.br; end
            2: begin tr = rnd(s.br + s.bi); ti = rnd(s.bi - s.br); end
            default: begin tr = rnd(s.bi - s.br); ti = rnd(-s.br - s.bi); end
        endcase
        ovr = 0;
        e1r = narrow(s.ar + tr, scale, sat, ovr);
        e1i = narrow(s.ai + ti, scale, sat, ovr);
        e2r = narrow(s.ar - tr, scale, sat, ovr);
        e2i = narrow(s.ai - ti, scale, sat, ovr);
    endfunction

    // record every accepted sample
    always @(posedge clk) if (!rst && in_valid && ir[0]) q.push_back('{int'(mode), sx(i1r), sx(i1i), sx(i2r), sx(i2i)});

    always @(posedge rst) q.delete();

    // check every valid output against the head of the queue, pop on handshake
    always @(negedge clk) begin
        if (!rst && vo[0]) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got out_valid=1, expected no pending sample");
            end else begin
                for (int k = 0; k < 3; k++) begin
                    longint e1r, e1i, e2r, e2i;
                    bit eo;
                    model(q[0], k == 2, k == 1, e1r, e1i, e2r, e2i, eo);
                    chk($sformatf("d%0d.valid", k), vo[k], 1);
                    chk($sformatf("d%0d.out_1_r", k), sx(o1r[k]), e1r);
                    chk($sformatf("d%0d.out_1_i", k), sx(o1i[k]), e1i);
                    chk($sformatf("d%0d.out_2_r", k), sx(o2r[k]), e2r);
                    chk($sformatf("d%0d.out_2_i", k), sx(o2i[k]), e2i);
                    if (eo) chk($sformatf("d%0d.ovf", k), ov[k], 1);
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    delivered++;
                end
            end
        end
    end

    task automatic drive(input bit v, input int m, input longint ar, input longint ai, input longint br, input longint bi);
        in_valid = v;
        mode = 2'(m);
        i1r = W'(ar);
        i1i = W'(ai);
        i2r = W'(br);
        i2i = W'(bi);
    endtask

    // single sample through an empty pipe with out_ready high; checks latency and literal results on instance 0
    task automatic vec(input string nm, input int m, input longint ar, input longint ai, input longint br, input longint bi,
                       input longint e1r, input longint e1i, input longint e2r, input longint e2i);
        @(posedge clk); #1;
        drive(1, m, ar, ai, br, bi);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk({nm, ".latency"}, vo[0], 0);
        @(negedge clk);
        chk({nm, ".valid"}, vo[0], 1);
        chk({nm, ".out_1_r"}, sx(o1r[0]), e1r);
        chk({nm, ".out_1_i"}, sx(o1i[0]), e1i);
        chk({nm, ".out_2_r"}, sx(o2r[0]), e2r);
        chk({nm, ".out_2_i"}, sx(o2i[0]), e2i);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        ovf_clr = 1;
        @(posedge clk); #1;
        ovf_clr = 0;
    endtask

    localparam int NV = 10;
    smp_t tab[NV] = '{
        '{0, -32768, -32768, -32768, -32768},
        '{1, 0, 0, -32768, 0},
        '{2, 32767, -32768, 32767, 32767},
        '{3, -32768, 32767, -32768, -32768},
        '{3, 1234, -4321, 32767, -32768},
        '{2, -100, 200, -300, 400},
        '{1, 32767, 32767, 32767, 32767},
        '{0, 5, -5, -7, 7},
        '{2, 0, 0, 1, 1},
        '{3, 0, 0, -1, 0}
    };

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint e1r, e1i, e2r, e2i;
        bit eo;
        int d, idx, cyc;
        bit acc;
        model('{2, 0, 0, 16384, 0}, 0, 0, e1r, e1i, e2r, e2i, eo);
        chk("model.mode2_r", e1r, 11585);
        chk("model.mode2_i", e1i, -11585);
        model('{0, 30000, 0, 10000, 0}, 0, 1, e1r, e1i, e2r, e2i, eo);
        chk("model.sat", e1r, 32767);
        chk("model.sat_ovf", longint'(eo), 1);

        #1 rst = 1;
        #2;
        chk("reset.in_ready", ir[0], 1);
        chk("reset.out_valid", vo[0], 0);
        chk("reset.ovf", ov[0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        vec("m0", 0, 100, 50, 20, -10, 120, 40, 80, 60);
        chk("m0.ovf", ov[0], 0);
        vec("m1", 1, 100, 50, 20, -10, 90, 30, 110, 70);
        vec("m2", 2, 0, 0, 16384, 0, 11585, -11585, -11585, 11585);
        vec("m3", 3, 0, 0, 16384, 0, -11585, -11585, 11585, 11585);
        chk("pre_ovf.d0", ov[0], 0);
        chk("pre_ovf.d2", ov[2], 0);
        vec("wrap", 0, 30000, 0, 10000, 0, -25536, 0, 20000, 0);
        chk("sat.out_1_r", sx(o1r[1]), 32767);
        chk("scale.out_1_r", sx(o1r[2]), 20000);
        chk("wrap.ovf", ov[0], 1);
        chk("sat.ovf", ov[1], 1);
        chk("scale.ovf", ov[2], 0);

        vec("sticky", 0, 1, 2, 3, 4, 4, 6, -2, -2);
        chk("sticky.ovf", ov[0], 1);
        pulse_clr();
        @(negedge clk);
        chk("clr.ovf", ov[0], 0);
        chk("clr.ovf_sat", ov[1], 0);

        @(posedge clk); #1;
        drive(1, 0, 30000, 0, 10000, 0);
        @(posedge clk); #1;
        in_valid = 0;
        ovf_clr = 1;
        @(posedge clk); #1;
        ovf_clr = 0;
        @(negedge clk);
        chk("set_wins.ovf", ov[0], 1);
        pulse_clr();

        @(posedge clk); #1;
        out_ready = 0;
        drive(1, 0, 1, 1, 1, 1);
        @(posedge clk); #1;
        drive(1, 1, 5, 6, 7, 8);
        @(posedge clk); #1;
        drive(1, 2, 100, 0, 16384, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp.in_ready", ir[0], 0);
            chk("bp.out_valid", vo[0], 1);
            chk("bp.hold_out_1_r", sx(o1r[0]), 2);
        end
        @(posedge clk); #1;
        out_ready = 1;
        d = delivered;
        @(negedge clk);
        chk("bp.in_ready_release", ir[0], 1);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("bp.second_valid", vo[0], 1);
        chk("bp.second_out_1_r", sx(o1r[0]), 13);
        @(negedge clk);
        chk("bp.third_valid", vo[0], 1);
        chk("bp.third_out_1_r", sx(o1r[0]), 11685);
        @(negedge clk);
        chk("bp.drained", vo[0], 0);
        chk("bp.delivered", delivered - d, 3);

        @(posedge clk); #1;
        drive(1, 0, 30000, 0, 10000, 0);
        @(posedge clk); #1;
        drive(1, 0, 3, 3, 3, 3);
        @(posedge clk); #1;
        in_valid = 0;
        chk("rst.pre_valid", vo[0], 1);
        chk("rst.pre_ovf", ov[0], 1);
        #2 rst = 1;
        #1;
        chk("rst.out_valid", vo[0], 0);
        chk("rst.ovf", ov[0], 0);
        chk("rst.in_ready", ir[0], 1);
        chk("rst.out_1_r", sx(o1r[0]), 0);
        @(posedge clk); #1;
        drive(1, 3, 0, 0, 16384, 0);
        rst = 0;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("rst.new_latency", vo[0], 0);
        @(negedge clk);
        chk("rst.new_valid", vo[0], 1);
        chk("rst.new_out_1_r", sx(o1r[0]), -11585);
        @(negedge clk);
        chk("rst.no_stale", vo[0], 0);

        idx = 0;
        cyc = 0;
        @(posedge clk); #1;
        while (idx < NV && cyc < 200) begin
            drive(1, tab[idx].m, tab[idx].ar, tab[idx].ai, tab[idx].br, tab[idx].bi);
            out_ready = (cyc % 3 != 2);
            @(negedge clk);
            acc = ir[0];
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("stream.accepted", idx, NV);
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("stream.drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the sample component width is W = 2**N bits, two's complement.
REQ-002 The module SHALL have parameter SCALE, default 0, where 1 means each output is divided by 2 (arithmetic shift right, truncating).
REQ-003 The module SHALL have parameter SAT, default 0, where 0 means outputs wrap modulo 2**W and 1 means outputs saturate to [-2**(W-1), 2**(W-1)-1].
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: the input sample pair is valid.
REQ-007 Port in_ready, output, 1 bit: the block accepts a sample when in_valid and in_ready are both high at a rising edge.
REQ-008 Port mode, input, 2 bits: twiddle select, sampled with the input.
REQ-009 Ports in_1_r, in_1_i, in_2_r, in_2_i, input, W bits each: the complex operands in_1 and in_2.
REQ-010 Port out_valid, output, 1 bit: the output pair is valid.
REQ-011 Port out_ready, input, 1 bit: the downstream consumer accepts the output.
REQ-012 Ports out_1_r, out_1_i, out_2_r, out_2_i, output, W bits each: the complex results.
REQ-013 Port ovf, output, 1 bit: sticky overflow flag.
REQ-014 Port ovf_clr, input, 1 bit: synchronous clear of ovf.

Function
REQ-015 Twiddle product t = in_2 * T SHALL be selected by mode as follows.
- mode 0: T = 1.
- mode 1: T = -i, so t = (in_2_i, -in_2_r).
- mode 2: T = (1-i)/sqrt2, so t = ((r+i)*C, (i-r)*C).
- mode 3: T = (-1-i)/sqrt2, so t = ((i-r)*C, (-r-i)*C).
REQ-016 C SHALL be round(2**(W-1)/sqrt2) in Q1.(W-1); for W=16, C = 23170.
REQ-017 In modes 2 and 3, the sums/differences SHALL be formed at W+1 bits and multiplied at full precision; 2**(W-2) SHALL be added, the result arithmetic-shifted right W-1, and saturated to W+1 bits.
REQ-018 Stage 1 register SHALL capture t, in_1 and a valid bit (s1_valid).
REQ-019 Stage 2 SHALL compute out_1 = in_1 + t and out_2 = in_1 - t at W+2 bits, apply SCALE, then wrap or saturate to W bits per SAT, and register the result with out_valid.
REQ-020 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready stays high; throughput SHALL be one sample per cycle.
REQ-021 Stage 2 SHALL advance when en2 = !out_valid | out_ready.
REQ-022 Stage 1 SHALL advance when en1 = !s1_valid | en2.
REQ-023 in_ready SHALL equal en1, combinationally.
REQ-024 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; no sample SHALL be lost, duplicated or reordered.
REQ-025 Acceptance and delivery in the same cycle with a full pipeline SHALL be permitted.
REQ-026 When a stage advances with no valid data behind it, its valid bit SHALL clear; its data registers are don't-care.
REQ-027 ovf SHALL be set in the cycle a sample whose final W-bit truncation of any output component changes its value is registered into stage 2, whether SAT is 0 or 1.
REQ-028 ovf SHALL remain set until ovf_clr; if set and clear coincide, set SHALL win.

Reset
REQ-029 On rst high, s1_valid, out_valid, ovf and all data registers SHALL go to 0 immediately, without waiting for a clock edge.
REQ-030 While rst is high, in_ready SHALL be 1.
REQ-031 In-flight samples at reset SHALL be discarded.
REQ-032 The first edge after rst falls SHALL be able to accept a sample.

Verification
REQ-033 mode 0, N=4, in_1=(100,50), in_2=(20,-10) -> 2 cycles later out_1=(120,40), out_2=(80,60), ovf=0.
REQ-034 mode 1, same inputs -> out_1=(90,30), out_2=(110,70).
REQ-035 mode 2, in_1=(0,0), in_2=(16384,0) -> out_1=(11585,-11585), out_2=(-11585,11585).
REQ-036 mode 0, in_1=(30000,0), in_2=(10000,0) -> with SAT=1, out_1_r=32767 and ovf=1; with SAT=0, out_1_r=-25536 and ovf=1; with SCALE=1, out_1_r=20000 and ovf=0.
REQ-037 Backpressure: hold out_ready=0 and offer 3 samples back-to-back -> 2 accepted, then in_ready=0 and outputs stable; raise out_ready -> samples delivered in order, one per cycle, and the third is accepted.
REQ-038 Reset mid-operation: assert rst between clock edges with both stages valid -> out_valid=0 and ovf=0 at once; after release, a new sample emerges after 2 cycles and no stale data appears.
